zero_det_sched: RTL
===================

// Module: zero_det_sched
// PURPOSE
//  Round-robin scheduler that shares one Moore zero-run detector among N_REQ requesters.
//  - Each granted requester supplies one WORD_W-bit word.
//  - The word is shifted LSB-first into the detector.
//  - Runs of >=2 consecutive zeros are counted; the count is returned with a done pulse.
//  - Sits between the serial-detector FSM and its client blocks; sole owner of the detector.
// PARAMETERS
//  N_REQ   4  number of requesters (>=2)
//  WORD_W  8  bits per word, shifted LSB-first
//  CNT_W   3  width of run_cnt; count saturates at 2**CNT_W-1
// PORTS
//  clock      in   1             rising-edge clock
//  reset      in   1             asynchronous, active-low reset
//  req        in   N_REQ         request bits; requester holds req and word until its gnt
//  word_in    in   N_REQ*WORD_W  requester i's word at [i*WORD_W +: WORD_W]
//  gnt        out  N_REQ         one-hot, one-cycle pulse; word captured on that cycle's edge
//  busy       out  1             high in SHIFT and DONE
//  done       out  1             one-cycle pulse; run_cnt and done_id valid only while high
//  done_id    out  $clog2(N_REQ) index of the requester whose result is presented
//  run_cnt    out  CNT_W         number of zero-runs of length >=2 in the word
//  det_state  out  2             current detector state (observability)
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, FSM=IDLE, det=S0, RR pointer last=N_REQ-1 (req[0] wins first).
//  Detector (Moore, out=state):
//   - S0=00: x=0->S1, x=1->S0
//   - S1=01: x=0->S2, x=1->S0
//   - S2=10: x=0->S2, x=1->S0
//   - 2'b11 is unreachable; it recovers to S0 on the next edge.
//  Controller FSM:
//   - IDLE: if |req at the edge -> SHIFT. Same edge: gnt<=one-hot winner, sreg<=winner word,
//     det<=S0, bit_idx<=0, cnt<=0, last<=winner, done_id<=winner. Otherwise stay, gnt=0.
//   - SHIFT: gnt<=0. Each edge feeds x=sreg[0] to the detector, then sreg>>=1 and bit_idx++.
//     cnt increments (saturating) when det==S1 && x==0, i.e. on the S1->S2 transition.
//     After WORD_W feed edges -> DONE.
//   - DONE: done=1 for exactly one cycle with run_cnt=cnt. Next edge -> IDLE.
//  Timing: done rises exactly WORD_W cycles after gnt rises. Issue period is WORD_W+2 cycles.
//  RR arbitration: the winner is the first set req scanning upward from (last+1) mod N_REQ.
//  Boundaries:
//   - req is ignored in SHIFT and DONE.
//   - A requester still holding req after its gnt is re-queued under normal RR order.
//   - A word with no zeros gives run_cnt=0. An all-zero word gives run_cnt=1.
//   - Detector state never carries across words (cleared at grant).
//   - Reset mid-SHIFT/DONE: immediate abort, no done, word lost, pointer back to N_REQ-1.
//   - run_cnt holds its last value outside DONE; consumers sample it only while done=1.
// CONFIGURATION
//  FIXED_PRIO_EN defined: fixed priority, lowest set req index always wins; pointer is unused.
//  FIXED_PRIO_EN undefined (default): round-robin as above.
// STRUCTURE
//  Package zero_det_pkg:
//   - det_state_t enum {S0=2'b00, S1=2'b01, S2=2'b10}
//   - sched_state_t enum {IDLE, SHIFT, DONE}
//   - DET_W=2
//  Sub-module zero_run_det: the Moore detector (clock, reset, clr, en, x_in -> state).
//  Arbiter, shift register, bit counter and saturating run counter stay in zero_det_sched.
// TESTING (defaults N_REQ=4, WORD_W=8, CNT_W=3)
//  1. Hold reset=0 for 3 cycles -> gnt=0, busy=0, done=0, run_cnt=0, det_state=00; release -> still IDLE.
//  2. req=4'b0001, word0=8'h00 -> gnt=4'b0001 for 1 cycle; done 8 cycles later, done_id=0, run_cnt=1.
//  3. req=4'b0100, word2=8'b0010_0100 -> done_id=2, run_cnt=3.
//     Then word2=8'hAA -> run_cnt=0; word2=8'hFF -> run_cnt=0, det_state stays 00.
//  4. req=4'b1111 held continuously -> gnt sequence 0001,0010,0100,1000,0001 spaced 10 cycles.
//     With FIXED_PRIO_EN -> 0001 every 10 cycles.
//  5. req=4'b0010, word1=8'h00; drive reset=0 on the 4th SHIFT cycle -> outputs 0 at once, no done.
//     After release, req=4'b0011 -> gnt=4'b0001 (pointer reset).
//  6. CNT_W=1, word0=8'b0010_0100 -> run_cnt=1 (saturated). req arriving during DONE is granted 2 cycles after done.

Source files
------------

// File: rtl/zero_det_pkg.sv
// Shared types for the zero-run detector scheduler: detector/controller state encodings.
package zero_det_pkg;

  localparam int DET_W = 2;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } det_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } sched_state_t;

endpackage

// File: rtl/zero_run_det.sv
// Moore detector tracking the current run of zeros (S0: none, S1: one, S2: two or more).
module zero_run_det
  import zero_det_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       x_in,
  output det_state_t state
);

  det_state_t nxt;

  always_comb begin
    nxt = state;
    if (clr) begin
      nxt = S0;
    end else begin
      case (state)
        S0:      if (en) nxt = x_in ? S0 : S1;
        S1:      if (en) nxt = x_in ? S0 : S2;
        S2:      if (en) nxt = x_in ? S0 : S2;
        // the unused 2'b11 code falls back to S0 whether or not a bit is fed
        default: nxt = S0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S0;
    else        state <= nxt;
  end

endmodule

// File: rtl/zero_det_sched.sv
// Scheduler sharing one zero-run detector among N_REQ requesters.
// Arbitration is round-robin by default; define FIXED_PRIO_EN for lowest-index-wins priority.
//
// Handshake: a requester raises req[i] with its word and holds both until gnt[i] pulses; the
// word is captured on that edge. The result comes back WORD_W cycles later as a one-cycle done
// pulse carrying done_id and run_cnt; there is no back-pressure on done.
module zero_det_sched
  import zero_det_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int WORD_W = 8,
  parameter  int CNT_W  = 3,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] word_in,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    done,
  output logic [ID_W-1:0]         done_id,
  output logic [CNT_W-1:0]        run_cnt,
  output logic [DET_W-1:0]        det_state,
  output logic [1:0]              sched_state
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  sched_state_t       state;
  det_state_t         det_q;
  logic [WORD_W-1:0]  sreg;
  logic [BIT_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [ID_W-1:0]    last;

  logic [ID_W-1:0]    win;
  logic [N_REQ-1:0]   win_oh;
  logic [WORD_W-1:0]  win_word;
  logic               found;

  always_comb begin
    win      = '0;
    win_oh   = '0;
    win_word = '0;
    found    = 1'b0;
`ifdef FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        win      = ID_W'(i);
        win_oh   = '0;
        win_oh[i] = 1'b1;
        win_word = word_in[i*WORD_W +: WORD_W];
      end
    end
`else
    // Scan offsets 1..N_REQ from the last winner; offset k lands on index last+k modulo N_REQ.
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && ((int'(last) + k == i) || (int'(last) + k == i + N_REQ))) begin
          found    = 1'b1;
          win      = ID_W'(i);
          win_oh   = '0;
          win_oh[i] = 1'b1;
          win_word = word_in[i*WORD_W +: WORD_W];
        end
      end
    end
`endif
  end

  // A run is counted once, on the bit that takes it from length one to length two.
  always_comb begin
    cnt_nxt = cnt;
    if (det_q == S1 && !sreg[0] && cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
  end

  zero_run_det u_det (
    .clock (clock),
    .reset (reset),
    .clr   (state == IDLE && (|req)),
    .en    (state == SHIFT),
    .x_in  (sreg[0]),
    .state (det_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      run_cnt <= '0;
      sreg    <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      last    <= ID_W'(N_REQ - 1);
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= SHIFT;
            gnt     <= win_oh;
            sreg    <= win_word;
            bit_idx <= '0;
            cnt     <= '0;
            last    <= win;
            done_id <= win;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          sreg    <= sreg >> 1;
          bit_idx <= bit_idx + 1'b1;
          cnt     <= cnt_nxt;
          if (bit_idx == LAST_BIT) begin
            state   <= DONE;
            done    <= 1'b1;
            run_cnt <= cnt_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign det_state   = det_q;
  assign sched_state = state;

endmodule
